// File: rtl/fetch_buffer_if.sv
// ============================================================================
// Module  : fetch_buffer_if
// Brief   : Bundle of the PC, instruction-memory and decode-side signals of
//           the fetch buffer. The master modport is the fetch buffer itself.
//           The slave modport is the surrounding pipeline or memory.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_buffer_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);

  // PC stage
  logic [ADDR_W-1:0] pc_in;
  logic              pc_stall;
  logic              flush;

  // Instruction memory
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rvalid;
  logic [DATA_W-1:0] imem_rdata;

  // Decode
  logic              id_valid;
  logic              id_ready;
  logic [DATA_W-1:0] id_instr;
  logic [ADDR_W-1:0] id_pc;

  modport master (
    input  pc_in,
    input  flush,
    input  imem_rvalid,
    input  imem_rdata,
    input  id_ready,
    output pc_stall,
    output imem_req,
    output imem_addr,
    output id_valid,
    output id_instr,
    output id_pc
  );

  modport slave (
    output pc_in,
    output flush,
    output imem_rvalid,
    output imem_rdata,
    output id_ready,
    input  pc_stall,
    input  imem_req,
    input  imem_addr,
    input  id_valid,
    input  id_instr,
    input  id_pc
  );

endinterface : fetch_buffer_if

`default_nettype wire

// File: rtl/fetch_buffer.sv
// ============================================================================
// Module  : fetch_buffer
// Brief   : Instruction-fetch buffer between the PC and decode. It issues
//           in-order fetches while credit remains (FIFO occupancy plus
//           in-flight requests below DEPTH). It pairs each response with its
//           address and presents {pc, instr} to decode. On flush it discards
//           queued and in-flight work.
//           Optional macro FETCH_PERF_EN adds saturating 16-bit stall and
//           drop counters as extra output ports.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  wire logic        clk,
  input  wire logic        reset,
  fetch_buffer_if.master   bus
`ifdef FETCH_PERF_EN
  ,
  output logic [15:0]      perf_stall_cnt,
  output logic [15:0]      perf_drop_cnt
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W:0]   c_depth_ext = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] c_cnt_zero  = '0;
  localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);
  localparam logic [PTR_W-1:0] c_ptr_one   = PTR_W'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0]  r_count;   // FIFO occupancy
  logic [CNT_W-1:0]  r_outst;   // requests issued and not yet answered
  logic [CNT_W-1:0]  r_drop;    // in-flight responses still to be discarded

  logic [PTR_W-1:0]  r_aq_wr;
  logic [PTR_W-1:0]  r_aq_rd;
  logic [PTR_W-1:0]  r_wr;
  logic [PTR_W-1:0]  r_rd;

  logic [ADDR_W-1:0] r_aq_mem    [DEPTH];
  logic [ADDR_W-1:0] r_pc_mem    [DEPTH];
  logic [DATA_W-1:0] r_instr_mem [DEPTH];

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic [CNT_W:0]    w_credit_sum;
  logic              w_issue;
  logic              w_valid;
  logic              w_push;
  logic              w_pop;
  logic              w_resp_discard;
  logic [CNT_W-1:0]  w_issue_inc;
  logic [CNT_W-1:0]  w_rvalid_dec;
  logic [CNT_W-1:0]  w_push_inc;
  logic [CNT_W-1:0]  w_pop_dec;

  // Issue requires credit, no flush, and reset released. The reset term makes
  // imem_req low and pc_stall high as soon as reset asserts.
  always_comb begin
    w_credit_sum   = {1'b0, r_count} + {1'b0, r_outst};
    w_issue        = reset && !bus.flush && (w_credit_sum < c_depth_ext);
    w_valid        = (r_count != c_cnt_zero);
    // A response is kept only when nothing is pending discard. A response
    // that arrives in the flush cycle is also thrown away.
    w_push         = bus.imem_rvalid && (r_drop == c_cnt_zero) && !bus.flush;
    w_resp_discard = bus.imem_rvalid && ((r_drop != c_cnt_zero) || bus.flush);
    w_pop          = w_valid && bus.id_ready && !bus.flush;
    w_issue_inc    = w_issue         ? c_cnt_one : c_cnt_zero;
    w_rvalid_dec   = bus.imem_rvalid ? c_cnt_one : c_cnt_zero;
    w_push_inc     = w_push          ? c_cnt_one : c_cnt_zero;
    w_pop_dec      = w_pop           ? c_cnt_one : c_cnt_zero;
  end

  // Drive the PC-stage, memory and decode outputs. Gating the head with
  // valid forces id_instr and id_pc to zero while the FIFO is empty.
  always_comb begin
    bus.imem_req  = w_issue;
    bus.imem_addr = bus.pc_in;
    bus.pc_stall  = !w_issue;
    bus.id_valid  = w_valid;
    bus.id_pc     = w_valid ? r_pc_mem[r_rd]    : '0;
    bus.id_instr  = w_valid ? r_instr_mem[r_rd] : '0;
  end

  // --------------------------------------------------------------------------
  // Address queue: remembers each issued PC until its response returns
  // --------------------------------------------------------------------------

  // Address-queue pointers. They are not cleared on flush: discarded
  // responses drain them in order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_aq_wr <= '0;
      r_aq_rd <= '0;
    end else begin
      if (w_issue) begin
        r_aq_wr <= r_aq_wr + c_ptr_one;
      end
      if (bus.imem_rvalid) begin
        r_aq_rd <= r_aq_rd + c_ptr_one;
      end
    end
  end

  // Address-queue storage; contents are meaningful only between the pointers.
  always_ff @(posedge clk) begin
    if (w_issue) begin
      r_aq_mem[r_aq_wr] <= bus.pc_in;
    end
  end

  // --------------------------------------------------------------------------
  // Output FIFO of {pc, instr} pairs
  // --------------------------------------------------------------------------

  // FIFO pointers and occupancy. Flush empties the FIFO and overrides any pop
  // or push in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else if (bus.flush) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + c_ptr_one;
      end
      if (w_pop) begin
        r_rd <= r_rd + c_ptr_one;
      end
      r_count <= r_count + w_push_inc - w_pop_dec;
    end
  end

  // FIFO storage. Writes take the PC from the head of the address queue.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_mem[r_wr]    <= r_aq_mem[r_aq_rd];
      r_instr_mem[r_wr] <= bus.imem_rdata;
    end
  end

  // --------------------------------------------------------------------------
  // In-flight and discard tracking
  // --------------------------------------------------------------------------

  // Count of outstanding requests. No issue happens in a flush cycle, so the
  // same update holds in every cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_outst <= '0;
    end else begin
      r_outst <= r_outst + w_issue_inc - w_rvalid_dec;
    end
  end

  // Discard counter. A flush marks every request still in flight after this
  // cycle for discard, so drop can never exceed outst.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_drop <= '0;
    end else if (bus.flush) begin
      r_drop <= r_outst - w_rvalid_dec;
    end else if (bus.imem_rvalid && (r_drop != c_cnt_zero)) begin
      r_drop <= r_drop - c_cnt_one;
    end
  end

`ifdef FETCH_PERF_EN
  // --------------------------------------------------------------------------
  // Performance counters (saturating)
  // --------------------------------------------------------------------------
  logic [CNT_W:0] w_drop_inc;
  logic [16:0]    w_stall_sum;
  logic [16:0]    w_drop_sum;

  // Increments: a stall is a cycle held for lack of credit, not a flush. A
  // drop is each FIFO entry cleared by flush plus each discarded response.
  always_comb begin
    w_drop_inc  = (bus.flush ? {1'b0, r_count} : '0)
                + (w_resp_discard ? (CNT_W + 1)'(1) : '0);
    w_stall_sum = {1'b0, perf_stall_cnt}
                + ((bus.pc_stall && !bus.flush) ? 17'd1 : 17'd0);
    w_drop_sum  = {1'b0, perf_drop_cnt} + 17'(w_drop_inc);
  end

  // Counter registers. Each saturates at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cnt <= '0;
      perf_drop_cnt  <= '0;
    end else begin
      perf_stall_cnt <= w_stall_sum[16] ? 16'hFFFF : w_stall_sum[15:0];
      perf_drop_cnt  <= w_drop_sum[16]  ? 16'hFFFF : w_drop_sum[15:0];
    end
  end
`else
  // The discard flag feeds only the optional counters.
  logic w_unused;
  always_comb begin
    w_unused = w_resp_discard;
  end
`endif

endmodule : fetch_buffer

`default_nettype wire
